// File: rtl/vga_stream_timing_if.sv
// Frame-RAM read port and VGA pin bundle for vga_stream_timing.
// master = timing generator side, slave = RAM / DAC side.
interface vga_stream_timing_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              hs;
  logic              vs;
  logic              de;
  logic [4:0]        vga_r;
  logic [5:0]        vga_g;
  logic [4:0]        vga_b;

  modport master (
    output rd_addr, hs, vs, de,
    output vga_r, vga_g, vga_b,
    input  rd_data
  );

  modport slave (
    input  rd_addr, hs, vs, de,
    input  vga_r, vga_g, vga_b,
    output rd_data
  );
endinterface

// File: rtl/vga_stream_timing.sv
// VGA sync/timing generator with upscaled frame-RAM address generation.
// Optional colour-bar test pattern: define VGA_TESTPAT_EN.
module vga_stream_timing #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int SCALE_SH = 1,
  parameter int SRC_W    = 320,
  parameter int ADDR_W   = 17,
  parameter int RD_LAT   = 1,
  parameter int CNT_W    = 11
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             pat_sel,
  output logic             frame_start,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  vga_stream_timing_if.master vif
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SY   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SY   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_AS   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_AE   = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] H_AL   = CNT_W'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [CNT_W-1:0] V_AS   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_AE   = CNT_W'(V_SYNC + V_BP + V_ACT);
  localparam logic [1:0]       SUB_MX = 2'((1 << SCALE_SH) - 1);
  localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        sub_q, sub_d;
  logic [ADDR_W-1:0] hold_q;
  logic [ADDR_W-1:0] addr_c;
  logic [CNT_W-1:0]  col_c;
  logic [RD_LAT:0]   hs_q, vs_q, de_q;
  logic [15:0]       rgb_q, rgb_d, pix_c;

  logic running, eof, h_in, v_in;
  logic hs_act, vs_act, de_raw, line_end;

  // State register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: start on run, stop only at end of frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (run)         state_d = RUN;
      RUN:  if (eof && !run) state_d = IDLE;
    endcase
  end

  // FSM outputs and raw (undelayed) timing flags
  always_comb begin
    running     = (state_q == RUN);
    eof         = (h_q == H_LAST) && (v_q == V_LAST);
    h_in        = (h_q >= H_AS) && (h_q < H_AE);
    v_in        = (v_q >= V_AS) && (v_q < V_AE);
    hs_act      = running && (h_q < H_SY);
    vs_act      = running && (v_q < V_SY);
    de_raw      = running && h_in && v_in;
    line_end    = running && v_in && (h_q == H_AL);
    frame_start = running && (h_q == '0) && (v_q == '0);
  end

  assign x_pos  = de_raw ? (h_q - H_AS) : '0;
  assign y_pos  = de_raw ? (v_q - V_AS) : '0;
  assign col_c  = x_pos >> SCALE_SH;
  assign addr_c = de_raw ? (base_q + ADDR_W'(col_c)) : hold_q;

  assign vif.rd_addr = addr_c;

  // Counter and line-base next state
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    base_d = base_q;
    sub_d  = sub_q;
    if (!running) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
    end else begin
      h_d = h_q + CNT_W'(1);
    end
    if (!running || (v_q < V_AS)) begin
      base_d = '0;
      sub_d  = '0;
    end else if (line_end) begin
      if (sub_q == SUB_MX) begin
        sub_d  = '0;
        base_d = base_q + SRC_A;
      end else begin
        sub_d = sub_q + 2'd1;
      end
    end
  end

  // Counters, line base, held address
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      base_q <= '0;
      sub_q  <= '0;
      hold_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      base_q <= base_d;
      sub_q  <= sub_d;
      hold_q <= addr_c;
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACT / 8 - 1);

  logic [2:0]       bar_q, bar_d;
  logic [CNT_W-1:0] bpx_q, bpx_d;
  logic [15:0]      bar_rgb;
  logic [RD_LAT-1:0] psel_q;
  logic [15:0]      pcol_q [RD_LAT];

  // Bar index tracks x_pos without a divider
  always_comb begin
    bar_d = '0;
    bpx_d = '0;
    if (de_raw) begin
      if (bpx_q == BAR_LAST) begin
        bar_d = bar_q + 3'd1;
        bpx_d = '0;
      end else begin
        bar_d = bar_q;
        bpx_d = bpx_q + CNT_W'(1);
      end
    end
  end

  // Bar colour lookup
  always_comb begin
    bar_rgb = 16'h0000;
    unique case (bar_q)
      3'd0: bar_rgb = 16'hFFFF;
      3'd1: bar_rgb = 16'hFFE0;
      3'd2: bar_rgb = 16'h07FF;
      3'd3: bar_rgb = 16'h07E0;
      3'd4: bar_rgb = 16'hF81F;
      3'd5: bar_rgb = 16'hF800;
      3'd6: bar_rgb = 16'h001F;
      3'd7: bar_rgb = 16'h0000;
    endcase
  end

  // Bar counters plus a pipe matching the RAM latency
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q  <= '0;
      bpx_q  <= '0;
      psel_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pcol_q[i] <= '0;
    end else begin
      bar_q     <= bar_d;
      bpx_q     <= bpx_d;
      psel_q[0] <= pat_sel;
      pcol_q[0] <= bar_rgb;
      for (int i = 1; i < RD_LAT; i++) begin
        psel_q[i] <= psel_q[i-1];
        pcol_q[i] <= pcol_q[i-1];
      end
    end
  end

  assign pix_c = psel_q[RD_LAT-1] ? pcol_q[RD_LAT-1] : vif.rd_data;
`else
  logic unused_pat_sel;
  assign unused_pat_sel = pat_sel;
  assign pix_c = vif.rd_data;
`endif

  // Pixel is captured when the delayed de says it is visible
  always_comb begin
    rgb_d = de_q[RD_LAT-1] ? pix_c : 16'h0000;
  end

  // Sync/de delay line and output pixel register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= '0;
      vs_q  <= '0;
      de_q  <= '0;
      rgb_q <= '0;
    end else begin
      hs_q  <= {hs_q[RD_LAT-1:0], hs_act};
      vs_q  <= {vs_q[RD_LAT-1:0], vs_act};
      de_q  <= {de_q[RD_LAT-1:0], de_raw};
      rgb_q <= rgb_d;
    end
  end

  assign vif.hs    = HS_POL ? hs_q[RD_LAT] : ~hs_q[RD_LAT];
  assign vif.vs    = VS_POL ? vs_q[RD_LAT] : ~vs_q[RD_LAT];
  assign vif.de    = de_q[RD_LAT];
  assign vif.vga_r = rgb_q[15:11];
  assign vif.vga_g = rgb_q[10:5];
  assign vif.vga_b = rgb_q[4:0];

endmodule

// File: tb/tb_vga_stream_timing.sv
// Directed bench for vga_stream_timing on a reduced 25x13 raster.
// RAM model returns data = address after RD_LAT cycles.
module tb_vga_stream_timing;

  localparam int RD_LAT = 2;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 11;

  logic             mclk;
  logic             rst_n;
  logic             run;
  logic             pat_sel;
  logic             frame_start;
  logic [CNT_W-1:0] x_pos;
  logic [CNT_W-1:0] y_pos;

  vga_stream_timing_if #(.ADDR_W(ADDR_W)) vif ();

  vga_stream_timing #(
    .H_SYNC(4), .H_BP(3), .H_ACT(16), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACT(8), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .SCALE_SH(1), .SRC_W(8), .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .run         (run),
    .pat_sel     (pat_sel),
    .frame_start (frame_start),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .vif         (vif.master)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic [15:0] ram_q [RD_LAT];
  always @(posedge mclk) begin
    ram_q[0] <= 16'(vif.rd_addr);
    for (int i = 1; i < RD_LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign vif.rd_data = ram_q[RD_LAT-1];

  int checks;
  int failures;
  int cyc;

  logic [15:0] rgb;
  assign rgb = {vif.vga_r, vif.vga_g, vif.vga_b};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge mclk);
    cyc++;
  endtask

  task automatic wait_fs(input string nm, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (frame_start) break;
      tick();
    end
    checks++;
    if (!frame_start) begin
      failures++;
      $display("FAIL %s: frame_start not seen within %0d cycles", nm, limit);
    end
    cyc = 0;
  endtask

  typedef struct {
    int          n;
    logic        run;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
    int          x;
    int          y;
    int          addr;
  } vec_t;

  vec_t vec [21];

  int cnt_hs, cnt_de, cnt_fs;
  int e_pat [4];
  int n_pat [4];

  initial begin
    vec[0]  = '{0,   1, 1, 1, 1, 0, 16'd0,  0,  0, 0};
    vec[1]  = '{3,   1, 0, 0, 0, 0, 16'd0,  0,  0, 0};
    vec[2]  = '{6,   1, 0, 0, 0, 0, 16'd0,  0,  0, 0};
    vec[3]  = '{7,   1, 0, 1, 0, 0, 16'd0,  0,  0, 0};
    vec[4]  = '{28,  1, 0, 0, 0, 0, 16'd0,  0,  0, 0};
    vec[5]  = '{53,  1, 0, 0, 1, 0, 16'd0,  0,  0, 0};
    vec[6]  = '{107, 1, 0, 1, 1, 0, 16'd0,  0,  0, 0};
    vec[7]  = '{109, 1, 0, 1, 1, 0, 16'd0,  2,  0, 1};
    vec[8]  = '{110, 1, 0, 1, 1, 1, 16'd0,  3,  0, 1};
    vec[9]  = '{112, 1, 0, 1, 1, 1, 16'd1,  5,  0, 2};
    vec[10] = '{122, 1, 0, 1, 1, 1, 16'd6,  15, 0, 7};
    vec[11] = '{123, 1, 0, 1, 1, 1, 16'd6,  0,  0, 7};
    vec[12] = '{125, 1, 0, 1, 1, 1, 16'd7,  0,  0, 7};
    vec[13] = '{126, 1, 0, 1, 1, 0, 16'd0,  0,  0, 7};
    vec[14] = '{128, 1, 0, 0, 1, 0, 16'd0,  0,  0, 7};
    vec[15] = '{134, 1, 0, 1, 1, 0, 16'd0,  2,  1, 1};
    vec[16] = '{159, 1, 0, 1, 1, 0, 16'd0,  2,  2, 9};
    vec[17] = '{162, 1, 0, 1, 1, 1, 16'd9,  5,  2, 10};
    vec[18] = '{297, 1, 0, 1, 1, 1, 16'd30, 15, 7, 31};
    vec[19] = '{300, 1, 0, 1, 1, 1, 16'd31, 0,  0, 31};
    vec[20] = '{325, 1, 1, 1, 1, 0, 16'd0,  0,  0, 31};

    n_pat = '{110, 112, 122, 125};
`ifdef VGA_TESTPAT_EN
    e_pat = '{32'hFFFF, 32'hFFE0, 32'h001F, 32'h0000};
`else
    e_pat = '{0, 1, 6, 7};
`endif

    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    pat_sel  = 1'b0;

    #12;
    chk("rst_hs",   32'(vif.hs), 1);
    chk("rst_vs",   32'(vif.vs), 1);
    chk("rst_de",   32'(vif.de), 0);
    chk("rst_rgb",  32'(rgb), 0);
    chk("rst_addr", 32'(vif.rd_addr), 0);
    chk("rst_fs",   32'(frame_start), 0);

    @(negedge mclk);
    rst_n = 1'b1;
    tick();
    chk("idle_fs", 32'(frame_start), 0);
    chk("idle_hs", 32'(vif.hs), 1);
    run = 1'b1;
    tick();
    wait_fs("start", 10);

    for (int i = 0; i < 21; i++) begin
      while (cyc < vec[i].n) tick();
      run = vec[i].run;
      chk($sformatf("v%0d_fs", i),   32'(frame_start), 32'(vec[i].fs));
      chk($sformatf("v%0d_hs", i),   32'(vif.hs),      32'(vec[i].hs));
      chk($sformatf("v%0d_vs", i),   32'(vif.vs),      32'(vec[i].vs));
      chk($sformatf("v%0d_de", i),   32'(vif.de),      32'(vec[i].de));
      chk($sformatf("v%0d_rgb", i),  32'(rgb),         32'(vec[i].rgb));
      chk($sformatf("v%0d_x", i),    32'(x_pos),       vec[i].x);
      chk($sformatf("v%0d_y", i),    32'(y_pos),       vec[i].y);
      chk($sformatf("v%0d_addr", i), 32'(vif.rd_addr), vec[i].addr);
    end

    // One full frame: sync duty, active area and frame period
    cnt_hs = 0;
    cnt_de = 0;
    cnt_fs = 0;
    for (int i = 0; i < 325; i++) begin
      if (!vif.hs)    cnt_hs++;
      if (vif.de)     cnt_de++;
      if (frame_start) cnt_fs++;
      tick();
    end
    chk("frame_hs_low", cnt_hs, 52);
    chk("frame_de_cnt", cnt_de, 128);
    chk("frame_fs_cnt", cnt_fs, 1);
    chk("frame_period", 32'(frame_start), 1);

    // Drop run mid-frame: frame completes, then idle
    cyc = 0;
    while (cyc < 130) tick();
    run = 1'b0;
    cnt_de = 0;
    cnt_fs = 0;
    for (int i = 0; i < 400; i++) begin
      if (vif.de)      cnt_de++;
      if (frame_start) cnt_fs++;
      tick();
    end
    chk("drop_de_cnt", cnt_de, 112);
    chk("drop_fs_cnt", cnt_fs, 0);
    chk("drop_idle_hs", 32'(vif.hs), 1);
    chk("drop_idle_vs", 32'(vif.vs), 1);
    run = 1'b1;
    tick();
    chk("restart_fs", 32'(frame_start), 1);
    cyc = 0;

    // Asynchronous reset in the middle of visible pixels
    while (cyc < 112) tick();
    chk("pre_rst_de", 32'(vif.de), 1);
    chk("pre_rst_rgb", 32'(rgb), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_hs",   32'(vif.hs), 1);
    chk("arst_vs",   32'(vif.vs), 1);
    chk("arst_de",   32'(vif.de), 0);
    chk("arst_rgb",  32'(rgb), 0);
    chk("arst_addr", 32'(vif.rd_addr), 0);
    chk("arst_x",    32'(x_pos), 0);
    tick();
    rst_n = 1'b1;
    chk("arst_rel_fs", 32'(frame_start), 0);
    tick();
    chk("arst_first_fs", 32'(frame_start), 1);
    cyc = 0;

    // Test pattern select
    pat_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      while (cyc < n_pat[i]) tick();
      chk($sformatf("pat%0d_rgb", i), 32'(rgb), e_pat[i]);
    end
    pat_sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
